// File: rtl/writeback_port_arbiter_if.sv
// Register-file write-port bundle: primary/secondary result inputs, write-port and status outputs.
// master drives the result sources; slave is the arbiter.
interface writeback_port_arbiter_if #(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_WIDTH = 32
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                  RegWriteW;
    logic [4:0]            RdW;
    logic [DATA_WIDTH-1:0] ResultW;
    logic                  SecValid;
    logic [4:0]            SecRd;
    logic [DATA_WIDTH-1:0] SecData;
    logic                  SecReady;
    logic                  WriteEnable;
    logic [4:0]            RegisterDest;
    logic [DATA_WIDTH-1:0] WriteData;
    logic [31:0]           PendingRd;
    logic [CW-1:0]         FifoCount;

    modport master (
        output RegWriteW, RdW, ResultW, SecValid, SecRd, SecData,
        input  SecReady, WriteEnable, RegisterDest, WriteData, PendingRd, FifoCount
    );

    modport slave (
        input  RegWriteW, RdW, ResultW, SecValid, SecRd, SecData,
        output SecReady, WriteEnable, RegisterDest, WriteData, PendingRd, FifoCount
    );
endinterface

// File: rtl/writeback_port_arbiter.sv
// Merges the in-order result (fixed priority) and queued long-latency results onto one RF write port.
// Write port is combinational, zero added latency; WB_SEC_BYPASS_EN lets an idle port take a secondary result directly.
// Backpressure: SecReady = !full (a same-cycle pop is not counted); the primary source is never stalled.
module writeback_port_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    writeback_port_arbiter_if.slave wb_io
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]            rd_q   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] vld_q, vld_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;

    logic prim_wr, fifo_empty, fifo_full, sec_acc, bypass, push, pop;
    logic [31:0] pend;

    assign prim_wr    = wb_io.RegWriteW && (wb_io.RdW != 5'd0);
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign sec_acc    = wb_io.SecValid && !fifo_full;

`ifdef WB_SEC_BYPASS_EN
    assign bypass = sec_acc && (wb_io.SecRd != 5'd0) && !prim_wr && fifo_empty;
`else
    assign bypass = 1'b0;
`endif

    // An x0 destination completes the handshake but is never stored.
    assign push = sec_acc && (wb_io.SecRd != 5'd0) && !bypass;
    assign pop  = !prim_wr && !fifo_empty;

    assign wb_io.SecReady  = !rst && !fifo_full;
    assign wb_io.FifoCount = count_q;

    always_comb begin
        wb_io.WriteEnable  = 1'b0;
        wb_io.RegisterDest = 5'd0;
        wb_io.WriteData    = '0;
        if (!rst) begin
            if (prim_wr) begin
                wb_io.WriteEnable  = 1'b1;
                wb_io.RegisterDest = wb_io.RdW;
                wb_io.WriteData    = wb_io.ResultW;
            end else if (!fifo_empty) begin
                wb_io.WriteEnable  = 1'b1;
                wb_io.RegisterDest = rd_q[rd_ptr_q];
                wb_io.WriteData    = data_q[rd_ptr_q];
            end else if (bypass) begin
                wb_io.WriteEnable  = 1'b1;
                wb_io.RegisterDest = wb_io.SecRd;
                wb_io.WriteData    = wb_io.SecData;
            end
        end
    end

    always_comb begin
        vld_d    = vld_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (pop) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + 1'b1;
        end
        if (push) begin
            vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    // Pending reflects stored entries; the head still counts during its own write cycle.
    always_comb begin
        pend = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (vld_q[i]) pend[rd_q[i]] = 1'b1;
        end
        pend[0] = 1'b0;
        wb_io.PendingRd = rst ? 32'd0 : pend;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[wr_ptr_q]   <= wb_io.SecRd;
            data_q[wr_ptr_q] <= wb_io.SecData;
        end
    end
endmodule
